// File: rtl/cascade_cmp_seq.sv
// Multi-word magnitude comparator streamed MSW first, with cascade inputs.
// Define CMP_SIGNED_EN to treat the most significant word as two's complement.
module cascade_cmp_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         first,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         Iagtb,
    input  logic         Iaeqb,
    input  logic         Ialtb,
    output logic         cgt,
    output logic         clt,
    output logic         ceq,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         Oagtb,
    output logic         Oaeqb,
    output logic         Oaltb
);

    localparam int CW = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORDS);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    typedef enum logic [1:0] {UND, GT, LT} dec_t;

    state_t        state_q, state_d;
    dec_t          dec_q, dec_d, dec_base;
    logic [CW-1:0] cnt_q, cnt_d, cnt_new;
    logic [2:0]    res_q, res_d;
    logic          accept;
    logic          start;

    assign ceq = (a == b);

`ifdef CMP_SIGNED_EN
    // MSW is signed; it is the beat that starts a pair
    logic sgn;
    assign sgn = (state_q == IDLE) || first;
    assign cgt = sgn ? ($signed(a) > $signed(b)) : (a > b);
`else
    assign cgt = (a > b);
`endif

    assign clt = !cgt && !ceq;

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign start     = (state_q == IDLE) || first;
    assign {Oagtb, Oaeqb, Oaltb} = res_q;

    always_comb begin
        state_d  = state_q;
        dec_d    = dec_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        dec_base = start ? UND : dec_q;
        cnt_new  = start ? CW'(1) : cnt_q + CW'(1);
        if (accept) begin
            dec_d = dec_base;
            if (dec_base == UND && !ceq)
                dec_d = cgt ? GT : LT;
            cnt_d = cnt_new;
            if (cnt_new == LAST) begin
                state_d = DONE;
                unique case (dec_d)
                    GT:      res_d = 3'b100;
                    LT:      res_d = 3'b001;
                    default: res_d = Iaeqb ? 3'b010 : {Iagtb, 1'b0, Ialtb};
                endcase
            end else begin
                state_d = CMP;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
            dec_d   = UND;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dec_q   <= UND;
            cnt_q   <= '0;
            res_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_cascade_cmp_seq.sv
// Directed bench for cascade_cmp_seq with N=4, WORDS=4.
// Expected results are hand-computed per vector.
module tb_cascade_cmp_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       first = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       Iagtb = 1'b0;
    logic       Iaeqb = 1'b0;
    logic       Ialtb = 1'b0;
    logic       cgt, clt, ceq;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       Oagtb, Oaeqb, Oaltb;

    int n_chk = 0;
    int n_fail = 0;
    logic [2:0] held;

    cascade_cmp_seq #(.N(4), .WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .first(first), .a(a), .b(b),
        .Iagtb(Iagtb), .Iaeqb(Iaeqb), .Ialtb(Ialtb),
        .cgt(cgt), .clt(clt), .ceq(ceq),
        .out_valid(out_valid), .out_ready(out_ready),
        .Oagtb(Oagtb), .Oaeqb(Oaeqb), .Oaltb(Oaltb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [3:0] av, input logic [3:0] bv,
                        input logic f, input logic [2:0] casc);
        a = av;
        b = bv;
        first = f;
        {Iagtb, Iaeqb, Ialtb} = casc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        first = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("pop_in_ready", {3'b0, in_ready}, 4'h1);
        chk("pop_out_valid", {3'b0, out_valid}, 4'h0);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", {3'b0, in_ready}, 4'h1);
        chk("rst_out_valid", {3'b0, out_valid}, 4'h0);
        chk("rst_res", {1'b0, Oagtb, Oaeqb, Oaltb}, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // GT decided at beat 2, with bubbles between beats
        beat(4'h3, 4'h3, 1'b1, 3'b000);
        a = 4'h5;
        b = 4'h4;
        #1;
        chk("comb_gt", {1'b0, cgt, ceq, clt}, 4'h4);
        beat(4'h5, 4'h4, 1'b0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("bubble_out_valid", {3'b0, out_valid}, 4'h0);
        beat(4'h0, 4'hF, 1'b0, 3'b000);
        chk("comb_lt", {1'b0, cgt, ceq, clt}, 4'h1);
        chk("pre_last_out_valid", {3'b0, out_valid}, 4'h0);
        beat(4'h0, 4'hF, 1'b0, 3'b001);
        chk("t1_out_valid", {3'b0, out_valid}, 4'h1);
        chk("t1_res", {1'b0, Oagtb, Oaeqb, Oaltb}, 4'h4);
        pop();

        // All equal, cascade decides
        beat(4'h2, 4'h2, 1'b1, 3'b000);
        chk("comb_eq", {1'b0, cgt, ceq, clt}, 4'h2);
        beat(4'h2, 4'h2, 1'b0, 3'b000);
        beat(4'h2, 4'h2, 1'b0, 3'b000);
        beat(4'h2, 4'h2, 1'b0, 3'b010);
        chk("t2a_res", {1'b0, Oagtb, Oaeqb, Oaltb}, 4'h2);
        pop();
        beat(4'h2, 4'h2, 1'b1, 3'b000);
        beat(4'h2, 4'h2, 1'b0, 3'b000);
        beat(4'h2, 4'h2, 1'b0, 3'b000);
        beat(4'h2, 4'h2, 1'b0, 3'b001);
        chk("t2b_res", {1'b0, Oagtb, Oaeqb, Oaltb}, 4'h1);
        pop();

        // Abort after beat 2 with first=1; old pair would be LT
        beat(4'h0, 4'h5, 1'b1, 3'b000);
        beat(4'h0, 4'h5, 1'b0, 3'b000);
        beat(4'h1, 4'h0, 1'b1, 3'b000);
        beat(4'h0, 4'h0, 1'b0, 3'b000);
        beat(4'h0, 4'h0, 1'b0, 3'b000);
        chk("t3_pre_out_valid", {3'b0, out_valid}, 4'h0);
        beat(4'h0, 4'h0, 1'b0, 3'b001);
        chk("t3_out_valid", {3'b0, out_valid}, 4'h1);
        chk("t3_res", {1'b0, Oagtb, Oaeqb, Oaltb}, 4'h4);

        // Back-pressure in DONE; offered beats must be ignored
        held = {Oagtb, Oaeqb, Oaltb};
        a = 4'h0;
        b = 4'hF;
        first = 1'b1;
        Iaeqb = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", {3'b0, in_ready}, 4'h0);
            chk("hold_out_valid", {3'b0, out_valid}, 4'h1);
            chk("hold_res", {1'b0, Oagtb, Oaeqb, Oaltb}, {1'b0, held});
        end
        in_valid = 1'b0;
        first = 1'b0;
        Iaeqb = 1'b0;
        pop();

        // Reset mid-pair discards the partial GT decision
        beat(4'h9, 4'h1, 1'b1, 3'b000);
        beat(4'h0, 4'h0, 1'b0, 3'b000);
        beat(4'h0, 4'h0, 1'b0, 3'b000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {3'b0, out_valid}, 4'h0);
        chk("arst_in_ready", {3'b0, in_ready}, 4'h1);
        chk("arst_res", {1'b0, Oagtb, Oaeqb, Oaltb}, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(4'h3, 4'h3, 1'b0, 3'b000);
        beat(4'h3, 4'h3, 1'b0, 3'b000);
        beat(4'h3, 4'h3, 1'b0, 3'b000);
        chk("t5_pre_out_valid", {3'b0, out_valid}, 4'h0);
        beat(4'h3, 4'h3, 1'b0, 3'b010);
        chk("t5_out_valid", {3'b0, out_valid}, 4'h1);
        chk("t5_res", {1'b0, Oagtb, Oaeqb, Oaltb}, 4'h2);
        pop();

        // MSW 8 vs 7: signed -8 < 7, unsigned 8 > 7
        a = 4'h8;
        b = 4'h7;
        #1;
`ifdef CMP_SIGNED_EN
        chk("comb_msw", {1'b0, cgt, ceq, clt}, 4'h1);
`else
        chk("comb_msw", {1'b0, cgt, ceq, clt}, 4'h4);
`endif
        beat(4'h8, 4'h7, 1'b1, 3'b000);
        a = 4'h8;
        b = 4'h7;
        #1;
        chk("comb_lower_unsigned", {1'b0, cgt, ceq, clt}, 4'h4);
        beat(4'h0, 4'h0, 1'b0, 3'b000);
        beat(4'h0, 4'h0, 1'b0, 3'b000);
        beat(4'h0, 4'h0, 1'b0, 3'b010);
`ifdef CMP_SIGNED_EN
        chk("t6_res", {1'b0, Oagtb, Oaeqb, Oaltb}, 4'h1);
`else
        chk("t6_res", {1'b0, Oagtb, Oaeqb, Oaltb}, 4'h4);
`endif
        pop();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cascade_cmp_seq.md
CASCADE_CMP_SEQ -- requirements
Module: cascade_cmp_seq

Interface
REQ-001 Parameter N, default 4: word width in bits; legal N >= 1.
REQ-002 Parameter WORDS, default 4: words per operand; legal WORDS >= 1; operand width is N*WORDS.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  beat offered on a, b, first, Iagtb, Iaeqb, Ialtb.
REQ-006 in_ready  output  1  block accepts a beat; a beat transfers when in_valid and in_ready are both 1.
REQ-007 first  input  1  beat carries the most significant word of a new operand pair.
REQ-008 a, b  input  N each  current operand words, streamed most significant word first.
REQ-009 Iagtb, Iaeqb, Ialtb  input  1 each  cascade inputs from a less significant stage; sampled only on the last beat.
REQ-010 cgt, clt, ceq  output  1 each  combinational compare of current a against b (greater, less, equal).
REQ-011 out_valid  output  1  registered result available.
REQ-012 out_ready  input  1  consumer takes the result; result transfers when out_valid and out_ready are both 1.
REQ-013 Oagtb, Oaeqb, Oaltb  output  1 each  registered final result for the whole operand pair.

Function
REQ-014 FSM states IDLE, CMP and DONE; in_ready shall be 1 in IDLE and CMP and 0 in DONE; out_valid shall be 1 only in DONE.
REQ-015 In IDLE any accepted beat shall be treated as the first word regardless of first; beat counter becomes 1.
REQ-016 In CMP an accepted beat with first=1 shall abort the pair in progress, clear the decision, and restart at beat 1.
REQ-017 The decision register shall hold UNDECIDED, GT or LT; UNDECIDED plus a != b on an accepted beat sets GT or LT; once GT or LT, later words shall not change it.
REQ-018 The accepted beat that brings the counter to WORDS is the last beat; the FSM shall enter DONE on the next edge, so out_valid rises one cycle after the last beat is accepted.
REQ-019 WORDS=1: the first accepted beat is also the last beat and shall go IDLE to DONE directly.
REQ-020 Final result: GT gives (Oagtb,Oaeqb,Oaltb)=(1,0,0); LT gives (0,0,1); UNDECIDED gives (0,1,0) if Iaeqb=1, else (Iagtb,0,Ialtb), with cascade inputs taken from the last beat.
REQ-021 The Oagtb, Oaeqb and Oaltb registers shall stay stable while out_valid=1 and out_ready=0.
REQ-022 DONE with out_ready=1 shall return to IDLE on the next edge; no beat is accepted in that cycle.
REQ-023 cgt, clt and ceq shall be exactly one-hot for any a, b and shall not depend on the handshake.
REQ-024 The beat counter shall be $clog2(WORDS+1) bits wide and shall never exceed WORDS.
REQ-025 in_valid=0 in CMP shall hold all state (bubbles allowed between beats).

Reset
REQ-026 rst_n low shall immediately force: state IDLE, counter 0, decision UNDECIDED, out_valid 0, Oagtb/Oaeqb/Oaltb 0; in_ready reads 1 while reset is held.
REQ-027 A reset asserted mid-pair or in DONE shall discard the partial or pending result; the first pair after release starts clean.

Configuration
REQ-028 Macro CMP_SIGNED_EN: when defined, the most significant word (beat 1) shall be compared as N-bit two's complement and all lower words unsigned.
REQ-029 Under CMP_SIGNED_EN, cgt/clt/ceq shall use signed compare when state is IDLE or first=1, and unsigned compare otherwise.
REQ-030 Without CMP_SIGNED_EN, all words and cgt/clt/ceq shall be compared unsigned; there is no signed logic.

Verification (N=4, WORDS=4)
REQ-031 a words 3,5,0,0 vs b words 3,4,F,F -> decided GT at beat 2; after the last beat out_valid=1, result (1,0,0).
REQ-032 All words equal (2,2,2,2); last beat Iaeqb=1 -> (0,1,0); repeat with Iaeqb=0, Iagtb=0, Ialtb=1 -> (0,0,1).
REQ-033 Beat 2 then first=1 with new words 1,0,0,0 vs 0,0,0,0 -> old pair discarded; result (1,0,0) one cycle after the 4th new beat.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-035 rst_n pulsed low after beat 3 -> out_valid 0 immediately; a fresh 4-beat pair completes normally.
REQ-036 With CMP_SIGNED_EN: MSW a=8 vs b=7 -> (0,0,1); without the macro the same stimulus -> (1,0,0).
